// File: rtl/reg_wr_arb_pkg.sv
// rtl/reg_wr_arb_pkg.sv - shared constants for the register write arbiter
// Purpose: default sizing for reg_wr_arb plus the register data width.
// Ports: none (package).
package reg_wr_arb_pkg;

  localparam int NREQ_DEF = 4;   // write requesters
  localparam int NREG_DEF = 8;   // registers served
  localparam int AW_DEF   = 3;   // register index width, log2(NREG_DEF)
  localparam int DW       = 32;  // register / write data width

endpackage

// File: rtl/reg32.sv
// rtl/reg32.sv - 32-bit register with write enable and set
// Purpose: one register-file entry; set loads all ones, we loads d.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (q -> 0)
//   we         load d on the rising edge
//   set        load all ones (takes priority over we)
//   d, q       data in / registered value
module reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        set,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (set) begin
      q <= '1;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_wr_arb_rr_pick.sv
// rtl/reg_wr_arb_rr_pick.sv - reusable round-robin picker with rotating pointer
// Purpose: picks the first set request searching upward from ptr (wrapping),
//          then moves ptr to winner+1 whenever a grant is issued.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (ptr -> 0)
//   i_en           grant enable; no grant and no ptr move when 0
//   i_req  [N]     request vector
//   o_gnt  [N]     one-hot-or-zero grant (combinational)
//   o_id   [PW]    index of the granted request
//   o_any          a grant is issued this cycle
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_id,
  output logic          o_any
);

  localparam logic [PW:0] L_N = (PW+1)'(N);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_s;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_nx;

  // Walk N positions starting at ptr; the first hit wins and blocks later ones.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    w_s   = '0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_s = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_s >= L_N) w_s = w_s - L_N;
      w_idx = w_s[PW-1:0];
      if (i_en && !o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
        o_any        = 1'b1;
      end
    end
  end

  // Next pointer is winner+1, wrapping at N (N need not be a power of 2).
  always_comb begin
    w_nx = {1'b0, o_id} + (PW+1)'(1);
    if (w_nx >= L_N) w_nx = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= w_nx[PW-1:0];
    end
  end

endmodule

// File: rtl/reg_wr_arb.sv
// rtl/reg_wr_arb.sv - round-robin arbiter funnelling N write requesters onto a register file
// Purpose: grants one requester per cycle, registers the winner's write as a
//          one-hot register enable plus shared write data.
// Config macro: REG_WR_ARB_PRIO0_EN - requester 0 always wins when valid and
//          not on hold; round-robin then covers requesters 1..NREQ-1 only.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   hold        suppress new grants
//   req_valid   per-requester write request            [NREQ]
//   req_addr    per-requester register index           [NREQ*AW]
//   req_data    per-requester write data               [NREQ*DW]
//   req_ready   one-hot-or-zero grant (combinational)  [NREQ]
//   rf_we       registered one-hot register enable     [NREG]
//   rf_wdata    registered write data                  [DW]
//   gnt_id      registered index of the writing requester
//   busy        registered, high while rf_we is nonzero
module reg_wr_arb
  import reg_wr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  localparam int GW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREG-1:0]    rf_we,
  output logic [DW-1:0]      rf_wdata,
  output logic [GW-1:0]      gnt_id,
  output logic               busy
);

  logic            w_en;
  logic            w_rr_en;
  logic [NREQ-1:0] w_rr_req;
  logic [NREQ-1:0] w_rr_gnt;
  logic [GW-1:0]   w_rr_id;
  logic            w_rr_any;
  logic [GW-1:0]   w_id;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  // Reset also blocks grants so nothing handshakes while rst is high.
  assign w_en = !hold && !rst;

`ifdef REG_WR_ARB_PRIO0_EN
  logic w_p0;
  assign w_p0      = w_en && req_valid[0];
  assign w_rr_req  = req_valid & ~NREQ'(1);
  assign w_rr_en   = w_en && !w_p0;
  assign req_ready = w_p0 ? NREQ'(1) : w_rr_gnt;
  assign w_id      = w_p0 ? '0 : w_rr_id;
  assign w_any     = w_p0 || w_rr_any;
`else
  assign w_rr_req  = req_valid;
  assign w_rr_en   = w_en;
  assign req_ready = w_rr_gnt;
  assign w_id      = w_rr_id;
  assign w_any     = w_rr_any;
`endif

  rr_pick #(
    .N  (NREQ),
    .PW (GW)
  ) u_rr_pick (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_rr_en),
    .i_req (w_rr_req),
    .o_gnt (w_rr_gnt),
    .o_id  (w_rr_id),
    .o_any (w_rr_any)
  );

  // AND-OR select of the granted requester's address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req_ready[k]) begin
        w_addr = req_addr[k*AW +: AW];
        w_data = req_data[k*DW +: DW];
      end
    end
  end

  // rf_we is a one-cycle pulse; wdata/gnt_id keep the last write's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= '0;
      rf_wdata <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
    end else if (w_any) begin
      rf_we    <= {{(NREG-1){1'b0}}, 1'b1} << w_addr;
      rf_wdata <= w_data;
      gnt_id   <= w_id;
      busy     <= 1'b1;
    end else begin
      rf_we    <= '0;
      busy     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_wr_arb.sv
// tb/tb_reg_wr_arb.sv - directed and randomised self-checking bench for reg_wr_arb
module tb_reg_wr_arb;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int AW   = 3;
`ifdef REG_WR_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREG-1:0]    rf_we;
  logic [31:0]        rf_wdata;
  logic [1:0]         gnt_id;
  logic               busy;
  logic [31:0]        rq [NREG];

  logic [AW-1:0] a [NREQ];
  logic [31:0]   d [NREQ];
  logic [31:0]   sh [NREG];
  int checks = 0;
  int errors = 0;

  reg_wr_arb #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  for (genvar g = 0; g < NREG; g++) begin : g_rf
    reg32 u_reg (
      .clk (clk),
      .rst (rst),
      .we  (rf_we[g]),
      .set (1'b0),
      .d   (rf_wdata),
      .q   (rq[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*AW +: AW] = a[k];
      req_data[k*32 +: 32] = d[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, k, m_ptr, pend_v, pend_a;
    logic [31:0] pend_d;
    logic [NREQ-1:0] gprev, exp_rdy;

    // Reset state with all requesters asking
    rst = 1'b1; hold = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin a[i] = AW'(i); d[i] = 32'h100 + i; end
    pack();
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_gnt", gnt_id, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("first_ready", req_ready, 4'b0001);

    // Fairness: grant order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      chk("fair_ready", req_ready, 1 << (i % 4));
      step();
      chk("fair_gnt", gnt_id, i % 4);
      chk("fair_we", rf_we, 1 << (i % 4));
      chk("fair_wdata", rf_wdata, 32'h100 + (i % 4));
      chk("fair_busy", busy, 1);
    end
    req_valid = 4'h0;
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wdata_hold", rf_wdata, 32'h100);
    chk("idle_gnt_hold", gnt_id, 0);
    for (int r = 0; r < NREG; r++) chk("fair_reg", rq[r], (r < 4) ? 32'h100 + r : 0);

    // Single write from requester 1 to index 3 (ptr is 1)
    req_valid = 4'b0010; a[1] = 3'd3; d[1] = 32'hDEADBEEF; pack();
    #1;
    chk("single_ready", req_ready, 4'b0010);
    step();
    chk("single_we", rf_we, 8'h08);
    chk("single_gnt", gnt_id, 1);
    req_valid = 4'h0;
    chk("single_reg_early", rq[3], 32'h103);
    step();
    chk("single_reg", rq[3], 32'hDEADBEEF);

    // Hold for 3 cycles, then release (ptr is 2)
    hold = 1'b1; req_valid = 4'hF; a[2] = 3'd6; d[2] = 32'h22222222; pack();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", req_ready, 0);
      step();
      chk("hold_we", rf_we, 0);
    end
    chk("hold_reg6", rq[6], 0);
    chk("hold_reg3", rq[3], 32'hDEADBEEF);
    hold = 1'b0;
    #1;
    chk("unhold_ready", req_ready, 4'b0100);
    step();
    chk("unhold_gnt", gnt_id, 2);
    chk("unhold_we", rf_we, 8'h40);
    hold = 1'b1; req_valid = 4'h0;
    step();
    chk("hold_keeps_write", rq[6], 32'h22222222);
    chk("hold_we_after", rf_we, 0);

    // Same-index collision (ptr is 3): 0 then 2 both to index 5
    hold = 1'b0; req_valid = 4'b0101;
    a[0] = 3'd5; d[0] = 32'hCAFEBABE; a[2] = 3'd5; d[2] = 32'h12345678; pack();
    #1;
    chk("col_ready0", req_ready, 4'b0001);
    step();
    chk("col_we0", rf_we, 8'h20);
    chk("col_wdata0", rf_wdata, 32'hCAFEBABE);
    req_valid = 4'b0100;
    #1;
    chk("col_ready2", req_ready, 4'b0100);
    step();
    chk("col_we2", rf_we, 8'h20);
    chk("col_wdata2", rf_wdata, 32'h12345678);
    chk("col_gnt2", gnt_id, 2);
    chk("col_reg_mid", rq[5], 32'hCAFEBABE);
    req_valid = 4'h0;
    step();
    chk("col_reg_final", rq[5], 32'h12345678);

    // Reset mid-operation with rf_we = 8'h04 pending
    req_valid = 4'b0001; a[0] = 3'd2; d[0] = 32'hA5A5A5A5; pack();
    step();
    chk("pre_rst_we", rf_we, 8'h04);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    for (int r = 0; r < NREG; r++) chk("mid_rst_reg", rq[r], 0);
    rst = 1'b0; req_valid = 4'hF;
    #1;
    chk("post_rst_ready", req_ready, 4'b0001);

    // Random traffic against a shadow model
    m_ptr = 0; pend_v = 0; pend_a = 0; pend_d = '0; gprev = '0;
    for (int r = 0; r < NREG; r++) sh[r] = '0;
    for (int c = 0; c < 200; c++) begin
      for (int q = 0; q < NREQ; q++) begin
        if (!(req_valid[q] && !gprev[q])) begin
          req_valid[q] = 1'($urandom_range(0, 1));
          a[q] = AW'($urandom_range(0, NREG - 1));
          d[q] = $urandom;
        end
      end
      hold = ($urandom_range(0, 3) == 0);
      pack();
      #1;
      w = -1;
      if (!hold) begin
        if (PRIO && req_valid[0]) w = 0;
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (w < 0 && req_valid[k] && !(PRIO && k == 0)) w = k;
        end
      end
      exp_rdy = (w < 0) ? '0 : NREQ'(1 << w);
      chk("rnd_ready", req_ready, exp_rdy);
      gprev = exp_rdy;
      if (w > 0 || (w == 0 && !PRIO)) m_ptr = (w + 1) % NREQ;
      step();
      if (pend_v != 0) sh[pend_a] = pend_d;
      pend_v = (w >= 0) ? 1 : 0;
      if (pend_v != 0) begin
        pend_a = int'(a[w]);
        pend_d = d[w];
      end
      chk("rnd_we", rf_we, (pend_v != 0) ? (1 << pend_a) : 0);
      chk("rnd_busy", busy, pend_v);
      if (pend_v != 0) begin
        chk("rnd_gnt", gnt_id, w);
        chk("rnd_wdata", rf_wdata, pend_d);
      end
      for (int r = 0; r < NREG; r++) chk("rnd_reg", rq[r], sh[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter NREG, default 8, number of 32-bit registers served (power of 2, 2..32).
REQ-003 Parameter AW, default 3, register index width; SHALL equal log2(NREG).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  when 1, no new grants are issued.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_addr  input  NREQ*AW  per-requester target register index; requester k occupies bits [k*AW +: AW].
REQ-009 req_data  input  NREQ*32  per-requester write data; requester k occupies bits [k*32 +: 32].
REQ-010 req_ready  output  NREQ  one-hot-or-zero grant, combinational from the inputs and the pointer.
REQ-011 rf_we  output  NREG  registered one-hot-or-zero write enable, one bit per register's we.
REQ-012 rf_wdata  output  32  registered write data, shared by all registers.
REQ-013 gnt_id  output  log2(NREQ)  registered index of the requester whose write is on rf_we.
REQ-014 busy  output  1  registered; 1 when rf_we is nonzero.

Function
REQ-015 A handshake completes in a cycle where req_valid[k] and req_ready[k] are both 1.
REQ-016 At most one req_ready bit SHALL be 1 per cycle; it is 0 for every k when hold=1 or no req_valid bit is set.
REQ-017 The winner SHALL be the first valid requester found searching upward from ptr, wrapping from NREQ-1 to 0.
REQ-018 ptr SHALL update to (winner+1) mod NREQ on a completed handshake and SHALL be unchanged otherwise.
REQ-019 On the edge that completes a handshake, rf_we SHALL become the one-hot decode of the winner's req_addr, rf_wdata its req_data, and gnt_id the winner index; the selected register loads on the following edge, so write latency is 2 edges from handshake.
REQ-020 With no completed handshake, rf_we SHALL be 0 after the edge; rf_wdata and gnt_id SHALL hold their last values.
REQ-021 Grants SHALL be issued back-to-back every cycle; two consecutive writes to the same index are both issued in order, the later value persisting.
REQ-022 Requesters SHALL hold req_addr and req_data stable while req_valid=1 and req_ready=0; the block imposes no timeout.
REQ-023 Asserting hold SHALL NOT cancel a write already registered onto rf_we.

Reset
REQ-024 While rst=1, without waiting for clk: ptr=0, rf_we=0, rf_wdata=0, gnt_id=0, busy=0.
REQ-025 req_ready SHALL be 0 while rst=1.
REQ-026 A registered write pending when rst rises SHALL be discarded (rf_we forced to 0).
REQ-027 The first grant after rst falls SHALL search from requester 0.

Configuration
REQ-028 Macro REG_WR_ARB_PRIO0_EN: when defined, requester 0 SHALL win whenever req_valid[0]=1 and hold=0, and ptr arbitration applies only among requesters 1..NREQ-1; when undefined, all requesters are pure round-robin per REQ-017.

Structure
REQ-029 Shared package reg_wr_arb_pkg SHALL hold the default NREQ/NREG/AW constants and the data width constant (32).
REQ-030 The round-robin pick and pointer logic SHALL be one sub-module, rr_pick, reused by other arbiters; reg_wr_arb instantiates rr_pick and owns the output registers.
REQ-031 The bench SHALL instantiate NREG reg32 instances driven by rf_we/rf_wdata with set tied 0, rst shared.

Verification
REQ-032 Reset: rst=1 mid-operation with rf_we=8'h04 -> within 1 ns rf_we=0, busy=0, req_ready=0, all reg32 read 0.
REQ-033 Single write: req_valid=4'b0010, addr1=3, data1=32'hDEADBEEF -> req_ready=4'b0010 same cycle; next edge rf_we=8'h08; register 3 reads DEADBEEF one edge later.
REQ-034 Fairness: all four valid continuously from reset -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-035 Hold: hold=1 with req_valid=4'b1111 for 3 cycles -> req_ready=0 throughout, registers unchanged; hold=0 -> grant to ptr's requester next cycle.
REQ-036 Same-index collision: requesters 0 and 2 both target index 5 with 32'hCAFEBABE and 32'h12345678 -> two back-to-back writes; register 5 ends at the later grantee's value.
REQ-037 Random: 200 cycles of random valid/addr/data/hold, shadow register model -> zero mismatches; with REG_WR_ARB_PRIO0_EN, req_valid[0]=1 always wins.
